// File: rtl/shift_pkg.sv
// Shared encodings and constants for the multi-cycle shift unit.
package shift_pkg;

  localparam int unsigned SHAMT_W = 5;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves acc by k positions in the direction given by op.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [SHAMT_W-1:0] k,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   acc_nxt
);

  always_comb begin
    acc_nxt = acc;
    case (op)
      SHIFT_SRL: acc_nxt = acc >> k;
      SHIFT_SRA: acc_nxt = WIDTH'($signed(acc) >>> k);
      // Reserved encoding 2'b11 behaves as a left shift.
      default:   acc_nxt = acc << k;
    endcase
  end

endmodule

// File: rtl/mc_shifter.sv
// Iterative shift unit for the EX stage: shifts up to STEP positions per cycle and returns
// the result over a valid/ready handshake.
module mc_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shamt,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   acc_nxt;

  // Upper shamt bits are architecturally ignored.
  logic unused_shamt;
  assign unused_shamt = ^shamt[31:SHAMT_W];

  assign k = (cnt_q < StepAmt) ? cnt_q : StepAmt;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc    (acc_q),
    .k      (k),
    .op     (op_q),
    .acc_nxt(acc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= SHIFT_SLL;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= data_in;
            cnt_q   <= shamt[SHAMT_W-1:0];
            op_q    <= op;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - k;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;

endmodule

// File: doc/mc_shifter.md
# mc_shifter

Multi-cycle shift unit for the MIPS datapath's EX stage. It consumes the zero-extended shift amount, whether from the instruction shamt field (sll/srl/sra) or from rs[4:0] (sllv/srlv/srav), together with the operand from rt. The shift is performed iteratively, STEP bit positions per cycle. The result is returned over a valid/ready handshake so the pipeline controller can stall EX while the unit is busy.

## Interface
- WIDTH, 32, operand/result width
- STEP, 1, max bit positions shifted per cycle (1, 2, 4 or 8)
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (acts as SLL)
- data_in  input  WIDTH  operand (rt)
- shamt  input  32  zero-extended shift amount; only bits [4:0] used, [31:5] ignored
- busy  output  1  high in SHIFT and DONE
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  shifted value

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1 at a rising edge: latch data_in into acc, shamt[4:0] into cnt, op into op_q, then go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, cnt!=0:
  - k = min(cnt, STEP).
  - Shift acc by k: SLL fills with zeros; SRL fills with zeros; SRA fills with acc[WIDTH-1] as sampled at that step.
  - cnt <= cnt - k.
- SHIFT, cnt==0: go to DONE; acc unchanged.
- DONE:
  - out_valid=1; result=acc.
  - On out_valid & out_ready: return to IDLE.
  - Otherwise hold DONE; result stays stable.
- start is ignored while busy=1; there is no queueing and no error flag.
- op=11 is treated exactly as SLL.
- Arithmetic: cnt is 5 bits, so the maximum shift is 31. A shamt of 32 or more wraps through bit truncation (shamt=33 shifts by 1).
- result is driven from acc in all states but is meaningful only while out_valid=1.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, op_q=00, busy=0, out_valid=0, result=0.
- Start accepted at edge E0.
- busy rises after E0.
- out_valid rises after edge E0 + ceil(n/STEP) + 1, where n = shamt[4:0].
  - STEP=1, n=0: out_valid after E0+1.
  - STEP=1, n=31: out_valid after E0+32.
- out_valid and busy fall after the edge where out_ready=1 is sampled in DONE.
- Back-to-back requests:
  - The earliest new start is accepted at the edge after the DONE→IDLE transition.
  - There is no same-edge DONE→SHIFT bypass.
- start and out_ready both high in DONE: only the handshake completes; start is dropped.
- rst asserted mid-shift: immediate return to reset values, with no pending result; the first start after rst deasserts is processed normally.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Structure
- Package shift_pkg holds:
  - the op encodings SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10;
  - the state enum {IDLE, SHIFT, DONE};
  - the shared constant SHAMT_W=5.
- Sub-module shift_step is natural: a combinational single-step shifter with ports (acc, k, op) → next acc, where k ranges 0..STEP.
  - It is reused by mc_shifter and by the bench reference model.
- mc_shifter contains the FSM, cnt, acc, op_q and output logic.

## Test plan
- Reset check: rst=1 mid-SHIFT (SLL 0x1 by 20, rst at cycle 5) → busy=0, out_valid=0, result=0; the next start (SRL 0x80000000 by 31) yields 0x00000001.
- SLL, STEP=1: data_in=0x00000001, shamt=0x1F → result 0x80000000 with out_valid exactly 32 cycles after accept.
- SRA sign fill: data_in=0x80000000, shamt=4 → 0xF8000000; SRL with the same inputs → 0x08000000.
- Zero shift and masking:
  - shamt=0 → result=data_in one cycle after accept.
  - shamt=0x00000021 → shift by 1 (0x00000003 SLL → 0x00000006).
- Handshake: hold out_ready=0 for 10 cycles in DONE while pulsing start with other data → result stable and start ignored; out_ready=1 → out_valid drops next edge.
- STEP=4: SRL 0xFFFFFFFF by 10 → 0x003FFFFF; out_valid 4 cycles after accept (steps of 4, 4, 2, then the terminal cycle).
